// File: rtl/tetris_field_renderer.sv
// Playfield renderer for the HDMI Tetris output path.
// Per frame: derives the cell size (blk) and the side margin (mgn) with a
// restoring divider, then converts the pixel/line position into cell
// coordinates, issues a cell lookup and emits the framed pixel after 2 cycles.
// Optional feature macro: GRID_LINES_EN draws mid-grey grid lines on the
// first column and first line of each cell (the borders still take priority).
`timescale 1ns/1ps
module tetris_field_renderer #(
  parameter int BITS_PER_COLOR = 4,
  parameter int HW             = 12,
  parameter int VW             = 12,
  parameter int COLS           = 10,
  parameter int ROWS           = 16,
  parameter int CXW            = 4,
  parameter int CYW            = 4,
  localparam int BPP           = 3*BITS_PER_COLOR
) (
  input  logic           i_pixclk,
  input  logic           i_reset,
  input  logic [HW-1:0]  i_width,
  input  logic [VW-1:0]  i_height,
  input  logic           i_rd,
  input  logic           i_newline,
  input  logic           i_newframe,
  output logic           o_cell_rd,
  output logic [CXW-1:0] o_cell_x,
  output logic [CYW-1:0] o_cell_y,
  input  logic [BPP-1:0] i_cell_pixel,
  output logic           o_geom_valid,
  output logic           o_valid,
  output logic [BPP-1:0] o_pixel
);
  localparam int CNTW   = $clog2(VW);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MARG, S_READY} state_e;
  typedef enum logic [1:0] {PX_BLACK, PX_WHITE, PX_GREY, PX_CELL} pcls_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  wid_q, fw_q, mgn_q;
  logic [VW-1:0]  hgt_q, quo_q, rem_q, blk_q, fh_q;
  logic [CNTW-1:0] cnt_q;
  logic [VW:0]    rs, rnext;
  logic           sub_ok;
  logic [HW-1:0]  fw_c, mgn_c;
  logic [VW-1:0]  fh_c;

  assign o_geom_valid = (state_q == S_READY);

  // Geometry FSM next state; a new frame always restarts the divide
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DIV:   if (cnt_q == CNTW'(VW-1)) state_d = S_MARG;
      S_MARG:  state_d = S_READY;
      default: state_d = state_q;
    endcase
    if (i_newframe) state_d = S_DIV;
  end

  // Geometry FSM state register
  always_ff @(posedge i_pixclk or posedge i_reset)
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;

  // One restoring-divide step (height / ROWS) and the margin arithmetic
  always_comb begin
    rs     = {rem_q, quo_q[VW-1]};
    sub_ok = (rs >= (VW+1)'(ROWS));
    rnext  = sub_ok ? rs - (VW+1)'(ROWS) : rs;
    fw_c   = HW'(COLS) * HW'(quo_q);
    mgn_c  = (fw_c > wid_q) ? '0 : (wid_q - fw_c) >> 1;
    fh_c   = VW'(ROWS) * quo_q;
  end

  // Geometry datapath: latch resolution, iterate divider, commit geometry
  always_ff @(posedge i_pixclk or posedge i_reset)
    if (i_reset) begin
      wid_q <= '0; hgt_q <= '0; quo_q <= '0; rem_q <= '0; cnt_q <= '0;
      blk_q <= '0; fw_q  <= '0; mgn_q <= '0; fh_q  <= '0;
    end else if (i_newframe) begin
      wid_q <= i_width; hgt_q <= i_height;
      quo_q <= i_height; rem_q <= '0; cnt_q <= '0;
    end else if (state_q == S_DIV) begin
      quo_q <= {quo_q[VW-2:0], sub_ok};
      rem_q <= VW'(rnext);
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == S_MARG) begin
      blk_q <= quo_q; fw_q <= fw_c; mgn_q <= mgn_c; fh_q <= fh_c;
    end

  // Stage 0: position and cell counters. xacc/yacc hold cx*blk and cy*blk so
  // cell edges are found by compare instead of division.
  logic [HW-1:0]  hpos_q, xacc_q, hpos_n;
  logic [VW-1:0]  ypos_q, yacc_q, ypos_n;
  logic [CXW-1:0] cx_q;
  logic [CYW-1:0] cy_q;
  logic           line_act_q;

  assign hpos_n = hpos_q + 1'b1;
  assign ypos_n = ypos_q + 1'b1;

  // Position tracking; newframe beats newline, lines without i_rd don't count
  always_ff @(posedge i_pixclk or posedge i_reset)
    if (i_reset) begin
      hpos_q <= '0; xacc_q <= '0; cx_q <= '0;
      ypos_q <= '0; yacc_q <= '0; cy_q <= '0; line_act_q <= 1'b0;
    end else if (i_newframe) begin
      hpos_q <= '0; xacc_q <= '0; cx_q <= '0;
      ypos_q <= '0; yacc_q <= '0; cy_q <= '0; line_act_q <= 1'b0;
    end else if (i_newline) begin
      hpos_q <= '0; xacc_q <= '0; cx_q <= '0; line_act_q <= 1'b0;
      if (line_act_q || i_rd) begin
        ypos_q <= ypos_n;
        if (ypos_n == yacc_q + blk_q && cy_q != CYW'(ROWS-1)) begin
          cy_q   <= cy_q + 1'b1;
          yacc_q <= yacc_q + blk_q;
        end
      end
    end else if (i_rd) begin
      hpos_q     <= hpos_n;
      line_act_q <= 1'b1;
      if (hpos_n == mgn_q + xacc_q + HW'(blk_q) && cx_q != CXW'(COLS-1)) begin
        cx_q   <= cx_q + 1'b1;
        xacc_q <= xacc_q + HW'(blk_q);
      end
    end

  // Stage 0 pixel classification in output priority order
  logic [HW-1:0] xr;
  pcls_e         cls0;
  logic          inside0;
  assign xr = mgn_q + fw_q;

  always_comb begin
    cls0    = PX_CELL;
    inside0 = 1'b0;
    if (!o_geom_valid || blk_q == '0)                          cls0 = PX_BLACK;
    else if (hpos_q == mgn_q || hpos_q == xr)                  cls0 = PX_WHITE;
    else if (hpos_q < mgn_q || hpos_q > xr || ypos_q >= fh_q)  cls0 = PX_BLACK;
    else begin
      inside0 = 1'b1;
      if (ypos_q == '0 || ypos_q == hgt_q - 1'b1)              cls0 = PX_WHITE;
`ifdef GRID_LINES_EN
      else if ((cx_q != '0 && hpos_q == mgn_q + xacc_q) ||
               (cy_q != '0 && ypos_q == yacc_q))               cls0 = PX_GREY;
`endif
      else                                                     cls0 = PX_CELL;
    end
  end

  // Stages 1-2: lookup strobe, class and valid pipeline
  logic [STAGES:1] vld_pipe_q;
  pcls_e           cls1_q, cls2_q;

  always_ff @(posedge i_pixclk or posedge i_reset)
    if (i_reset) begin
      vld_pipe_q <= '0; o_cell_rd <= 1'b0; o_cell_x <= '0; o_cell_y <= '0;
      cls1_q <= PX_BLACK; cls2_q <= PX_BLACK;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], i_rd};
      o_cell_rd  <= i_rd && inside0;
      o_cell_x   <= cx_q;
      o_cell_y   <= cy_q;
      cls1_q     <= i_rd ? cls0 : PX_BLACK;
      cls2_q     <= cls1_q;
    end

  assign o_valid = vld_pipe_q[STAGES];

`ifdef GRID_LINES_EN
  localparam logic [BPP-1:0] GREY_PIX = {3{1'b1, {(BITS_PER_COLOR-1){1'b0}}}};
`endif

  // Stage 2 output mux; cell colour arrives one cycle after the strobe
  always_comb begin
    o_pixel = '0;
    case (cls2_q)
      PX_WHITE: o_pixel = '1;
      PX_CELL:  o_pixel = i_cell_pixel;
`ifdef GRID_LINES_EN
      PX_GREY:  o_pixel = GREY_PIX;
`endif
      default:  o_pixel = '0;
    endcase
  end
endmodule

// File: tb/tb_tetris_field_renderer.sv
// Directed bench for tetris_field_renderer: table of {line, pixel, expected}
// for a 640x480 frame plus hand sequences for timing, restart and reset.
`timescale 1ns/1ps
module tb_tetris_field_renderer;
`ifdef GRID_LINES_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif
  localparam logic [11:0] WH = 12'hFFF, BK = 12'h000, GR = 12'h888;

  logic        clk = 1'b0, rst = 1'b1;
  logic [11:0] i_width = '0, i_height = '0;
  logic        i_rd = 1'b0, i_newline = 1'b0, i_newframe = 1'b0;
  logic        o_cell_rd, o_geom_valid, o_valid;
  logic [3:0]  o_cell_x, o_cell_y;
  logic [11:0] i_cell_pixel, o_pixel;

  tetris_field_renderer dut (
    .i_pixclk(clk), .i_reset(rst), .i_width(i_width), .i_height(i_height),
    .i_rd(i_rd), .i_newline(i_newline), .i_newframe(i_newframe),
    .o_cell_rd(o_cell_rd), .o_cell_x(o_cell_x), .o_cell_y(o_cell_y),
    .i_cell_pixel(i_cell_pixel), .o_geom_valid(o_geom_valid),
    .o_valid(o_valid), .o_pixel(o_pixel));

  always #5 clk = ~clk;

  // Cell store: colour encodes the looked-up coordinates; poison when no strobe
  always @(posedge clk) i_cell_pixel <= o_cell_rd ? {o_cell_x, o_cell_y, 4'h5} : 12'h0F0;

  // Output capture, indexed by running count of valid pixels
  int          vtot = 0;
  logic [11:0] pix_log [0:2047];
  always @(negedge clk) if (o_valid === 1'b1) begin
    pix_log[vtot % 2048] = o_pixel;
    vtot++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] px(input int base, input int i);
    return pix_log[(base + i) % 2048];
  endfunction

  function automatic int nonzero(input int base, input int n);
    int nz = 0;
    for (int i = 0; i < n; i++) if (px(base, i) !== 12'h000) nz++;
    return nz;
  endfunction

  task automatic pulse_nf(input int w, input int h);
    @(negedge clk); i_width = 12'(w); i_height = 12'(h); i_newframe = 1'b1;
    @(negedge clk); i_newframe = 1'b0;
  endtask

  // Valid must be low in cycle 13 and high in cycle 14 after the pulse
  task automatic wait_geom(input string nm);
    repeat (12) @(posedge clk);
    @(negedge clk); chk({nm, " geom c13"}, {31'd0, o_geom_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk); chk({nm, " geom c14"}, {31'd0, o_geom_valid}, 32'd1);
  endtask

  task automatic run_line(input int n, output int base);
    @(negedge clk); i_newline = 1'b1;
    @(negedge clk); i_newline = 1'b0; i_rd = 1'b1; base = vtot;
    repeat (n) @(negedge clk);
    i_rd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct { int line; int pix; logic [11:0] exp; } vec_t;
  vec_t vq[$];
  task automatic add(input int l, input int p, input logic [11:0] e);
    vec_t v; v.line = l; v.pix = p; v.exp = e; vq.push_back(v);
  endtask

  initial begin
    int b;
    // 640x480: blk=30, mgn=170, fw=300, right border at 470
    add(0, 169, BK);  add(0, 170, WH);  add(0, 171, WH);  add(0, 300, WH);
    add(0, 470, WH);  add(0, 471, BK);
    add(5, 0, BK);    add(5, 169, BK);  add(5, 170, WH);  add(5, 171, 12'h005);
    add(5, 199, 12'h005); add(5, 200, GRID ? GR : 12'h105);
    add(5, 469, 12'h905); add(5, 470, WH); add(5, 471, BK);
    add(31, 171, 12'h015); add(31, 200, GRID ? GR : 12'h115);
    add(31, 440, GRID ? GR : 12'h915);
    add(479, 169, BK); add(479, 170, WH); add(479, 300, WH);
    add(479, 470, WH); add(479, 471, BK);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst outs", {o_cell_rd, o_geom_valid, o_valid, o_cell_x, o_cell_y, o_pixel}, 32'd0);
    rst = 1'b0;

    // Main frame
    pulse_nf(640, 480);
    wait_geom("640x480");
    for (int l = 0; l < 480; l++) begin
      bit cap = (l == 0 || l == 5 || l == 31 || l == 479);
      run_line(cap ? 472 : 1, b);
      if (cap) chk($sformatf("vcnt L%0d", l), vtot - b, 472);
      foreach (vq[i])
        if (vq[i].line == l)
          chk($sformatf("L%0d px%0d", l, vq[i].pix), {20'd0, px(b, vq[i].pix)}, {20'd0, vq[i].exp});
    end

    // o_valid trails a lone i_rd by two cycles
    @(negedge clk); i_newline = 1'b1;
    @(negedge clk); i_newline = 1'b0; i_rd = 1'b1;
    @(negedge clk); i_rd = 1'b0; chk("valid +1", {31'd0, o_valid}, 32'd0);
    @(negedge clk); chk("valid +2", {31'd0, o_valid}, 32'd1);
    @(negedge clk); chk("valid +3", {31'd0, o_valid}, 32'd0);

    // blk = 0: everything black
    pulse_nf(640, 8);
    wait_geom("h8");
    run_line(1, b); run_line(1, b); run_line(472, b);
    chk("blk0 nonblack", nonzero(b, 472), 0);

    // Field wider than screen: mgn = 0, right border at 300
    pulse_nf(200, 480);
    wait_geom("200x480");
    for (int l = 0; l < 5; l++) run_line(1, b);
    run_line(302, b);
    chk("w200 px0", {20'd0, px(b, 0)}, {20'd0, WH});
    chk("w200 px1", {20'd0, px(b, 1)}, 32'h005);
    chk("w200 px30", {20'd0, px(b, 30)}, GRID ? {20'd0, GR} : 32'h105);
    chk("w200 px199", {20'd0, px(b, 199)}, 32'h605);
    chk("w200 px299", {20'd0, px(b, 299)}, 32'h905);
    chk("w200 px300", {20'd0, px(b, 300)}, {20'd0, WH});
    chk("w200 px301", {20'd0, px(b, 301)}, 32'h000);

    // Restart mid-divide: second sample (480) must win over first (8)
    pulse_nf(640, 8);
    repeat (5) @(negedge clk);
    pulse_nf(640, 480);
    wait_geom("restart");
    for (int l = 0; l < 5; l++) run_line(1, b);
    run_line(472, b);
    chk("restart px170", {20'd0, px(b, 170)}, {20'd0, WH});
    chk("restart px200", {20'd0, px(b, 200)}, GRID ? {20'd0, GR} : 32'h105);

    // Asynchronous reset mid-line
    @(negedge clk); i_newline = 1'b1;
    @(negedge clk); i_newline = 1'b0; i_rd = 1'b1;
    repeat (250) @(negedge clk);
    chk("pre-rst busy", {o_valid, o_geom_valid, o_cell_rd}, 32'd7);
    chk("pre-rst cx", {28'd0, o_cell_x}, 32'd2);
    #2 rst = 1'b1;
    #1 chk("async rst outs", {o_cell_rd, o_geom_valid, o_valid, o_cell_x, o_cell_y, o_pixel}, 32'd0);
    i_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_line(472, b);
    chk("post-rst nonblack", nonzero(b, 472), 0);
    chk("post-rst geom", {31'd0, o_geom_valid}, 32'd0);
    pulse_nf(640, 480);
    wait_geom("reinit");
    for (int l = 0; l < 5; l++) run_line(1, b);
    run_line(472, b);
    chk("reinit px200", {20'd0, px(b, 200)}, GRID ? {20'd0, GR} : 32'h105);
    chk("reinit px471", {20'd0, px(b, 471)}, 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
